// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives per-stage write enables and bubble
// flushes for data-memory wait states, MEM-stage redirects and load-use hazards.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_memRead,
    input  logic             exmem_memWrite,
    input  logic             exmem_branch_taken,
    input  logic             exmem_jump,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2
    } state_e;

    // Control pattern selected for the current cycle.
    typedef enum logic [1:0] {
        PatNormal,
        PatRedirect,
        PatBubble,
        PatFreeze
    } pat_e;

    localparam logic [3:0]  StallInit = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] Timeout   = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       remain_q, remain_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             err_q, err_d;
    pat_e             pat;

    logic mem_access;
    logic load_use;
    logic redirect;
    logic mem_hold;

    assign mem_access = exmem_memRead | exmem_memWrite;
    assign redirect   = exmem_branch_taken | exmem_jump;
    assign load_use   = idex_memRead & (idex_rt != 5'd0) &
                        ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
    // Outside MEM_WAIT a pending access stalls; inside it only dmem_ready matters.
    assign mem_hold   = (state_q == StMemWait) ? ~dmem_ready : (mem_access & ~dmem_ready);

    always_comb begin
        state_d  = StRun;
        remain_d = remain_q;
        wait_d   = wait_q;
        err_d    = err_q;
        pat      = PatNormal;

        if (mem_hold) begin
            pat = PatFreeze;
            if (state_q == StMemWait) begin
                if (wait_q >= Timeout) begin
                    err_d   = 1'b1;
                    state_d = StRun;
                end else begin
                    wait_d  = wait_q + 16'd1;
                    state_d = StMemWait;
                end
            end else begin
                wait_d  = 16'd1;
                state_d = StMemWait;
            end
        end else if (redirect) begin
            pat     = PatRedirect;
            state_d = StRun;
        end else if (state_q == StLoadStall) begin
            pat      = PatBubble;
            remain_d = remain_q - 4'd1;
            state_d  = (remain_d == 4'd0) ? StRun : StLoadStall;
        end else if (load_use) begin
            pat      = PatBubble;
            remain_d = StallInit;
            state_d  = (StallInit != 4'd0) ? StLoadStall : StRun;
        end else begin
            pat     = PatNormal;
            state_d = StRun;
        end
    end

    logic       pc_en_c, pc_redirect_c;
    logic [3:0] en_c, flush_c;   // {ifid, idex, exmem, memwb}

    always_comb begin
        pc_en_c       = 1'b1;
        pc_redirect_c = 1'b0;
        en_c          = 4'b1111;
        flush_c       = 4'b0000;
        unique case (pat)
            PatNormal: begin
                pc_en_c = 1'b1;
            end
            PatRedirect: begin
                pc_redirect_c = 1'b1;
                flush_c       = 4'b1110;
            end
            PatBubble: begin
                pc_en_c = 1'b0;
                en_c    = 4'b0111;
                flush_c = 4'b0100;
            end
            PatFreeze: begin
                pc_en_c = 1'b0;
                en_c    = 4'b0001;
                flush_c = 4'b0001;
            end
            default: begin
                pc_en_c = 1'b1;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en_c && !(&stall_q)) begin
            stall_d = stall_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            remain_q <= 4'd0;
            wait_q   <= 16'd0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    // Reset forces every control low immediately, independent of the clock.
    assign pc_en        = rst_n & pc_en_c;
    assign pc_redirect  = rst_n & pc_redirect_c;
    assign ifid_en      = rst_n & en_c[3];
    assign idex_en      = rst_n & en_c[2];
    assign exmem_en     = rst_n & en_c[1];
    assign memwb_en     = rst_n & en_c[0];
    assign ifid_flush   = rst_n & flush_c[3];
    assign idex_flush   = rst_n & flush_c[2];
    assign exmem_flush  = rst_n & flush_c[1];
    assign memwb_flush  = rst_n & flush_c[0];
    assign state_o      = state_q;
    assign stall_cycles = stall_q;
    assign mem_err      = err_q;

endmodule
